// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package if_fetch_pkg;

  localparam int          W_ADDR = 32;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  typedef struct packed {
    logic [W_ADDR-1:0] pc;
    logic [31:0]       inst;
    logic              adel;
  } fetch_t;

  function automatic logic addr_misaligned(input logic [W_ADDR-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - SRAM-like instruction bus (addr/data handshake)
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic              inst_req;
  logic [W_ADDR-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [31:0]       inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID boundary register, priority flush > stall > load > bubble
module if_id_reg
  import if_fetch_pkg::*;
#(
  parameter logic [W_ADDR-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              load,
  input  fetch_t            load_data,
  output logic              if_valid,
  output logic [W_ADDR-1:0] if_pc,
  output logic [31:0]       if_inst,
  output logic              if_adel
);

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_pc    <= RESET_PC;
      if_inst  <= NOP;
      if_adel  <= 1'b0;
    end else if (flush) begin
      if_valid <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        if_valid <= 1'b1;
        if_pc    <= load_data.pc;
        if_inst  <= load_data.inst;
        if_adel  <= load_data.adel;
      end else begin
        // nothing completed this cycle: hand ID a bubble
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: one outstanding bus request, hold buffer, redirect drop
// Optional macro IF_ADDR_CHECK_EN: misaligned fetches raise if_adel instead of going to the bus.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [W_ADDR-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid,
  input  logic [W_ADDR-1:0] pc_addr,
  input  logic              stall,
  input  logic              flush,
  output logic              fetch_stall,
  if_fetch_if.master        bus,
  output logic              if_valid,
  output logic [W_ADDR-1:0] if_pc,
  output logic [31:0]       if_inst,
  output logic              if_adel
);

  state_t state;
  fetch_t hold_buf;
  fetch_t load_data;
  logic   misaligned;
  logic   done;

`ifdef IF_ADDR_CHECK_EN
  assign misaligned    = (state == S_ADDR) && addr_misaligned(pc_addr);
  assign bus.inst_addr = pc_addr;
`else
  assign misaligned    = 1'b0;
  assign bus.inst_addr = {pc_addr[W_ADDR-1:2], 2'b00};
`endif

  assign bus.inst_req = (state == S_ADDR) && !misaligned;
  assign done         = ((state == S_DATA) && bus.inst_data_ok) ||
                        (state == S_HOLD) || misaligned;
  // released on flush so the PC can take the redirect target
  assign fetch_stall  = pc_valid && !flush && !(done && !stall);

  always_comb begin
    load_data = '{pc: pc_addr, inst: bus.inst_rdata, adel: 1'b0};
    if (state == S_HOLD) begin
      load_data = hold_buf;
    end else if (misaligned) begin
      load_data = '{pc: pc_addr, inst: NOP, adel: 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      hold_buf <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pc_valid) state <= S_ADDR;
        end
        S_ADDR: begin
          // without addr_ok a flush just lets the new pc_addr re-present
          if (bus.inst_req && bus.inst_addr_ok) state <= flush ? S_DROP : S_DATA;
        end
        S_DATA: begin
          if (bus.inst_data_ok) begin
            if (flush) begin
              state <= S_ADDR;
            end else if (stall) begin
              state    <= S_HOLD;
              hold_buf <= '{pc: pc_addr, inst: bus.inst_rdata, adel: 1'b0};
            end else begin
              state <= S_ADDR;
            end
          end else if (flush) begin
            state <= S_DROP;
          end
        end
        S_DROP: begin
          // the stale response must still be consumed exactly once
          if (bus.inst_data_ok) state <= S_ADDR;
        end
        S_HOLD: begin
          if (flush || !stall) state <= S_ADDR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  if_id_reg #(
    .RESET_PC (RESET_PC)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall     (stall),
    .load      (done),
    .load_data (load_data),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .if_adel   (if_adel)
  );

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage sitting directly downstream of the PC register.
- Takes the current fetch address and issues it on an SRAM-like instruction bus (addr/data handshake).
- Back-pressures the PC while a fetch is in flight and registers the fetched instruction into the IF/ID boundary.
- Discards in-flight responses on a redirect (flush from exception or branch).

Parameters:
- RESET_PC, 32'h00000000, value driven on if_pc while if_valid=0 after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pc_valid  in  1  PC out of reset (PC's run flag)
- pc_addr  in  `W_ADDR  current fetch address, held by PC while fetch_stall=1
- stall  in  1  ID cannot accept an instruction this cycle
- flush  in  1  redirect; kill current fetch and IF/ID contents
- fetch_stall  out  1  to PC stall input
- inst_req  out  1  bus request
- inst_addr  out  `W_ADDR  bus address
- inst_addr_ok  in  1  request accepted
- inst_data_ok  in  1  read data valid
- inst_rdata  in  32  read data
- if_valid  out  1  IF/ID holds a valid instruction
- if_pc  out  `W_ADDR  PC of that instruction
- if_inst  out  32  instruction word
- if_adel  out  1  fetch address error flag

Behaviour:
- Reset (synchronous, highest priority):
  - state=IDLE; if_valid=0, if_pc=RESET_PC, if_inst=0, if_adel=0.
  - Hold buffer cleared.
  - Any bus response arriving after reset is ignored; the bus is reset with the core.
- States:
  - IDLE: pc_valid=1 -> ADDR.
  - ADDR: inst_req=1, inst_addr=pc_addr.
    - inst_addr_ok & !flush -> DATA.
    - inst_addr_ok & flush -> DROP.
    - flush without inst_addr_ok -> stay ADDR; the request re-presents with the new pc_addr next cycle.
  - DATA: inst_req=0.
    - inst_data_ok & flush -> ADDR, data discarded.
    - inst_data_ok & stall -> HOLD, rdata latched in hold buffer with pc.
    - inst_data_ok & !stall -> ADDR, IF/ID loaded.
    - !inst_data_ok & flush -> DROP.
  - DROP: wait for inst_data_ok, discard it -> ADDR. A flush here keeps DROP.
  - HOLD: flush -> ADDR, buffer dropped. !stall -> IF/ID loaded from buffer -> ADDR.
- Completion: done = (DATA & inst_data_ok) | HOLD.
- fetch_stall = pc_valid & !flush & !(done & !stall).
  - Combinational.
  - Deasserted on flush so the PC takes the redirect.
- IF/ID register priority: flush -> if_valid=0; else stall -> hold; else done -> load; else if_valid=0 (bubble).
- Throughput: best case 1 instruction / 2 cycles. data_ok is never sampled in the same cycle as addr_ok.
- At most one outstanding request; DROP guarantees each response is consumed exactly once.

Optional Feature:
- Macro: IF_ADDR_CHECK_EN.
- Defined:
  - In ADDR with pc_addr[1:0]!=0, inst_req is held 0.
  - The cycle counts as done.
  - IF/ID loads if_inst=0, if_adel=1, if_pc=pc_addr.
  - Stall/flush rules are unchanged.
- Undefined:
  - inst_addr[1:0] is forced to 2'b00.
  - if_adel is tied to 0.

Decomposition:
- defines.vh: `W_ADDR, state encodings (IDLE/ADDR/DATA/HOLD/DROP), NOP word.
- One natural sub-module: if_id_reg, the IF/ID boundary register with the flush > stall > load priority.
- The FSM and hold buffer stay in if_fetch.

Test Plan:
1. Reset, then pc_valid=1, pc_addr=0, addr_ok cycle 2, data_ok=0x24020001 cycle 3 -> if_valid=1, if_pc=0, if_inst=0x24020001 cycle 4; fetch_stall=0 only in cycle 3.
2. data_ok with stall=1 for 3 cycles -> state HOLD, fetch_stall=1, if_* unchanged. stall drops -> if_inst=held word next cycle.
3. flush one cycle after addr_ok, data_ok two cycles later -> response discarded, if_valid=0, next inst_req carries the new pc_addr (0xBFC00380).
4. flush coincident with data_ok -> if_valid=0 next cycle, state ADDR, no duplicate instruction.
5. rst asserted in DATA -> all outputs at reset values next cycle; late data_ok produces no if_valid.
6. (IF_ADDR_CHECK_EN) pc_addr=0x00000002 -> inst_req never asserted, if_adel=1, if_inst=0, if_pc=0x00000002.
